capture_async_fifo: RTL and testbench



---
 rtl/capture_async_fifo_gray_sync.sv | 23 ++
 rtl/capture_async_fifo.sv | 109 ++++++++++
 tb/tb_capture_async_fifo.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/capture_async_fifo_gray_sync.sv
// rtl/capture_async_fifo_gray_sync.sv - two-flop synchroniser for a Gray-coded pointer
module capture_async_fifo_gray_sync #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/capture_async_fifo.sv
// rtl/capture_async_fifo.sv - dual-clock FWFT capture FIFO, core_clk write side to sdram_clk read side
module capture_async_fifo #(
  parameter int DATA_W            = 16,
  parameter int ADDR_W            = 10,
  parameter int PROG_EMPTY_THRESH = 64
) (
  input  logic              core_clk,
  input  logic              core_rst,
  input  logic              sdram_clk,
  input  logic              sdram_rst,
  input  logic [DATA_W-1:0] din,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              prog_empty
);

  localparam int PTR_W = ADDR_W + 1;

  function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic [PTR_W-1:0] wbin, wgray, wbin_next, wgray_next, rgray_sync;
  logic [PTR_W-1:0] rbin, rgray, rbin_next, wgray_sync, wsync_bin, ram_count;
  logic             wr_fire, full_next, ram_empty, load, valid;

  // Write domain
  assign wr_fire    = wr_en & ~full;
  assign wbin_next  = wbin + PTR_W'(wr_fire);
  assign wgray_next = bin2gray(wbin_next);
  assign full_next  = (wgray_next == {~rgray_sync[PTR_W-1:PTR_W-2], rgray_sync[PTR_W-3:0]});

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      wbin  <= '0;
      wgray <= '0;
      full  <= 1'b0;
    end else begin
      wbin  <= wbin_next;
      wgray <= wgray_next;
      full  <= full_next;
    end
  end

  always_ff @(posedge core_clk) begin
    if (wr_fire) begin
      mem[wbin[ADDR_W-1:0]] <= din;
    end
  end

  capture_async_fifo_gray_sync #(.WIDTH(PTR_W)) u_rptr_sync (
    .clk (core_clk),
    .rst (core_rst),
    .d   (rgray),
    .q   (rgray_sync)
  );

  capture_async_fifo_gray_sync #(.WIDTH(PTR_W)) u_wptr_sync (
    .clk (sdram_clk),
    .rst (sdram_rst),
    .d   (wgray),
    .q   (wgray_sync)
  );

  // Read domain: the output stage refills whenever it is empty or being popped
  assign ram_empty = (rgray == wgray_sync);
  assign load      = ~ram_empty & (~valid | rd_en);
  assign rbin_next = rbin + PTR_W'(load);
  assign wsync_bin = gray2bin(wgray_sync);
  // Post-load pointer keeps the occupancy count from ever reading high
  assign ram_count = wsync_bin - rbin_next;

  always_ff @(posedge sdram_clk or posedge sdram_rst) begin
    if (sdram_rst) begin
      rbin       <= '0;
      rgray      <= '0;
      valid      <= 1'b0;
      dout       <= '0;
      prog_empty <= 1'b1;
    end else begin
      rbin       <= rbin_next;
      rgray      <= bin2gray(rbin_next);
      prog_empty <= (ram_count <= PTR_W'(PROG_EMPTY_THRESH));
      if (load) begin
        dout  <= mem[rbin[ADDR_W-1:0]];
        valid <= 1'b1;
      end else if (rd_en) begin
        valid <= 1'b0;
      end
    end
  end

  assign empty = ~valid;

endmodule

// File: tb/tb_capture_async_fifo.sv
// tb/tb_capture_async_fifo.sv - randomized scoreboard bench for capture_async_fifo
`timescale 1ns/1ps
module tb_capture_async_fifo;

  logic        core_clk, core_rst, sdram_clk, sdram_rst;
  logic [15:0] din, dout;
  logic        wr_en, rd_en, full, empty, prog_empty;

  int errors = 0;
  int checks = 0;
  logic [15:0] model_q[$];
  realtime sdram_half = 3.75;

  capture_async_fifo dut (
    .core_clk   (core_clk),
    .core_rst   (core_rst),
    .sdram_clk  (sdram_clk),
    .sdram_rst  (sdram_rst),
    .din        (din),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .dout       (dout),
    .full       (full),
    .empty      (empty),
    .prog_empty (prog_empty)
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;
  initial sdram_clk = 1'b0;
  always #(sdram_half) sdram_clk = ~sdram_clk;

  task automatic push_word(input logic [15:0] v);
    @(negedge core_clk);
    wr_en = 1'b1;
    din   = v;
    if (!full) model_q.push_back(v);
    @(negedge core_clk);
    wr_en = 1'b0;
  endtask

  task automatic pop_word(output logic [15:0] v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge sdram_clk);
      if (!empty) begin
        ok = 1'b1;
        break;
      end
    end
    v = dout;
    if (ok) begin
      rd_en = 1'b1;
      @(negedge sdram_clk);
      rd_en = 1'b0;
    end
  endtask

  task automatic apply_reset();
    @(negedge core_clk);
    core_rst  = 1'b1;
    sdram_rst = 1'b1;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    repeat (4) @(negedge core_clk);
    core_rst  = 1'b0;
    sdram_rst = 1'b0;
    model_q.delete();
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    repeat (5) @(negedge sdram_clk);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (prog_empty !== 1'b1) begin errors++; $display("FAIL reset_prog_empty: got %b expected 1", prog_empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
    checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL reset_dout: got %h expected 0000", dout); end
  endtask

  task automatic test_single_word();
    int edges;
    edges = 0;
    @(negedge core_clk);
    wr_en = 1'b1;
    din   = 16'hA5A5;
    @(posedge core_clk);
    #1;
    wr_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge sdram_clk);
      #1;
      edges++;
      if (!empty) break;
    end
    checks++; if (!(empty === 1'b0 && edges <= 4)) begin errors++; $display("FAIL single_latency: got %0d edges empty=%b expected <=4 edges", edges, empty); end
    checks++; if (dout !== 16'hA5A5) begin errors++; $display("FAIL single_dout: got %h expected a5a5", dout); end
    @(negedge sdram_clk);
    rd_en = 1'b1;
    @(negedge sdram_clk);
    rd_en = 1'b0;
    repeat (2) @(negedge sdram_clk);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty_after_read: got %b expected 1", empty); end
  endtask

  task automatic test_fill();
    int accepted, got, first, last, bad, bad_idx;
    logic [15:0] bad_val;
    accepted = 0; got = 0; first = -1; last = -1; bad = 0; bad_idx = -1; bad_val = '0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge core_clk);
      wr_en = 1'b1;
      din   = 16'(i);
      if (!full) accepted++;
    end
    @(negedge core_clk);
    wr_en = 1'b0;
    repeat (10) @(negedge core_clk);
    checks++; if (accepted !== 1025) begin errors++; $display("FAIL fill_accepted: got %0d expected 1025", accepted); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b expected 1", full); end
    @(negedge sdram_clk);
    rd_en = 1'b1;
    for (int c = 0; c < 1200; c++) begin
      if (!empty) begin
        if (dout !== 16'(got) && bad == 0) begin bad_idx = got; bad_val = dout; end
        if (dout !== 16'(got)) bad++;
        if (first < 0) first = c;
        last = c;
        got++;
      end
      @(negedge sdram_clk);
    end
    rd_en = 1'b0;
    checks++; if (got !== 1025) begin errors++; $display("FAIL fill_drain_count: got %0d expected 1025", got); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL fill_drain_order: %0d bad words, first at %0d value %h expected %h", bad, bad_idx, bad_val, 16'(bad_idx)); end
    checks++; if (last - first !== 1024) begin errors++; $display("FAIL fill_back_to_back: got span %0d expected 1024", last - first); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fill_empty_after: got %b expected 1", empty); end
    repeat (6) @(negedge core_clk);
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL fill_full_released: got %b expected 0", full); end
  endtask

  task automatic test_prog_empty();
    logic [15:0] v, exp;
    bit ok;
    int bad;
    bad = 0;
    for (int i = 0; i < 70; i++) push_word(16'($urandom));
    repeat (20) @(negedge sdram_clk);
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL prog_not_empty: got %b expected 0", empty); end
    checks++; if (prog_empty !== 1'b0) begin errors++; $display("FAIL prog_empty_69_in_ram: got %b expected 0", prog_empty); end
    for (int i = 0; i < 4; i++) begin
      pop_word(v, ok);
      exp = model_q.pop_front();
      checks++; if (!ok || v !== exp) begin errors++; $display("FAIL prog_pop%0d: got %h ok=%b expected %h", i, v, ok, exp); end
    end
    repeat (3) @(negedge sdram_clk);
    checks++; if (prog_empty !== 1'b0) begin errors++; $display("FAIL prog_empty_65_in_ram: got %b expected 0", prog_empty); end
    pop_word(v, ok);
    exp = model_q.pop_front();
    checks++; if (!ok || v !== exp) begin errors++; $display("FAIL prog_pop4: got %h ok=%b expected %h", v, ok, exp); end
    repeat (3) @(negedge sdram_clk);
    checks++; if (prog_empty !== 1'b1) begin errors++; $display("FAIL prog_empty_64_in_ram: got %b expected 1", prog_empty); end
    while (model_q.size() > 0) begin
      pop_word(v, ok);
      exp = model_q.pop_front();
      if (!ok || v !== exp) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL prog_drain: got %0d bad words expected 0", bad); end
    repeat (3) @(negedge sdram_clk);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL prog_empty_after_drain: got %b expected 1", empty); end
  endtask

  task automatic test_streaming();
    int sent, popped, bad, underflow;
    bit saw_full;
    logic [15:0] exp, next_word;
    sent = 0; popped = 0; bad = 0; underflow = 0; saw_full = 1'b0;
    sdram_half = 13.5;
    next_word = 16'($urandom);
    fork
      begin
        for (int c = 0; c < 45000 && sent < 5000; c++) begin
          @(negedge core_clk);
          wr_en = 1'($urandom_range(0, 1));
          din   = next_word;
          if (full) saw_full = 1'b1;
          if (wr_en && !full) begin
            model_q.push_back(next_word);
            sent++;
            next_word = 16'($urandom);
          end
        end
        @(negedge core_clk);
        wr_en = 1'b0;
      end
      begin
        for (int c = 0; c < 15000 && popped < 5000; c++) begin
          @(negedge sdram_clk);
          rd_en = ($urandom_range(0, 3) != 0);
          if (rd_en && !empty) begin
            if (model_q.size() == 0) underflow++;
            else begin
              exp = model_q.pop_front();
              if (dout !== exp) bad++;
            end
            popped++;
          end
        end
        @(negedge sdram_clk);
        rd_en = 1'b0;
      end
    join
    repeat (10) @(negedge sdram_clk);
    checks++; if (popped !== 5000) begin errors++; $display("FAIL stream_count: got %0d expected 5000", popped); end
    checks++; if (bad !== 0 || underflow !== 0) begin errors++; $display("FAIL stream_order: got %0d bad %0d extra expected 0 0", bad, underflow); end
    checks++; if (empty !== 1'b1 || model_q.size() !== 0) begin errors++; $display("FAIL stream_drained: got empty=%b left=%0d expected 1 0", empty, model_q.size()); end
    checks++; if (saw_full !== 1'b1) begin errors++; $display("FAIL stream_full_seen: got %b expected 1", saw_full); end
    sdram_half = 3.75;
  endtask

  task automatic test_mid_reset();
    logic [15:0] v;
    bit ok;
    for (int i = 0; i < 10; i++) push_word(16'($urandom));
    repeat (10) @(negedge sdram_clk);
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL midrst_queued: got empty=%b expected 0", empty); end
    apply_reset();
    checks++; if (empty !== 1'b1 || prog_empty !== 1'b1 || full !== 1'b0 || dout !== 16'h0) begin
      errors++; $display("FAIL midrst_flags: got empty=%b prog_empty=%b full=%b dout=%h expected 1 1 0 0000", empty, prog_empty, full, dout);
    end
    repeat (5) @(negedge sdram_clk);
    push_word(16'h1234);
    pop_word(v, ok);
    checks++; if (!ok || v !== 16'h1234) begin errors++; $display("FAIL midrst_first_word: got %h ok=%b expected 1234", v, ok); end
    repeat (3) @(negedge sdram_clk);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL midrst_empty_after: got %b expected 1", empty); end
  endtask

  initial begin
    core_rst  = 1'b1;
    sdram_rst = 1'b1;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    din       = '0;
    test_reset();
    test_single_word();
    test_fill();
    test_prog_empty();
    test_streaming();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
